// File: rtl/demux_capture.sv
// Bit-serial capture into a 7-slot word with Valid/Ack handshake.
// Define DEMUX_AUTO_EN to build the auto-increment slot pointer.
module demux_capture #(
  parameter int WIDTH = 7,
  parameter int SELW  = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [SELW-1:0]  DemuxSelect,
  input  logic             In,
  input  logic             WrEn,
  input  logic             AutoMode,
  input  logic             Ack,
  output logic [WIDTH-1:0] Out,
  output logic             Valid,
  output logic             Overrun
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] wrmask;
  logic [WIDTH-1:0] mask_base;
  logic [WIDTH-1:0] mask_nxt;
  logic [WIDTH-1:0] onehot;
  logic [SELW-1:0]  tgt;
  logic             restart;
  logic             accept;
  logic             tgt_ok;
  logic             do_wr;
  logic             drop;

`ifdef DEMUX_AUTO_EN
  logic [SELW-1:0]  ptr;
  logic [SELW-1:0]  ptr_base;
  logic [SELW-1:0]  ptr_inc;
`else
  logic             unused_auto;
  assign unused_auto = AutoMode;
`endif

  // Target selection and next write mask; Ack in HOLD opens a new frame
  // in the same cycle so a coincident write lands in that new frame.
  always_comb begin
    restart   = (state == HOLD) && Ack;
    accept    = WrEn && ((state == COLLECT) || restart);
    drop      = WrEn && (state == HOLD) && !Ack;
    mask_base = restart ? '0 : wrmask;
`ifdef DEMUX_AUTO_EN
    ptr_base  = restart ? '0 : ptr;
    ptr_inc   = (ptr_base == SELW'(WIDTH - 1)) ? '0
              : ptr_base + SELW'(1);
    tgt       = AutoMode ? ptr_base : DemuxSelect;
`else
    tgt       = DemuxSelect;
`endif
    tgt_ok    = 32'(tgt) < WIDTH;
    do_wr     = accept && tgt_ok;
    onehot    = WIDTH'(1) << tgt;
    mask_nxt  = mask_base | (do_wr ? onehot : '0);
  end

  // Frame state, data, mask and sticky overrun flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= COLLECT;
      wrmask  <= '0;
      Out     <= '0;
      Overrun <= 1'b0;
    end else begin
      wrmask <= mask_nxt;
      if (do_wr)
        Out <= (Out & ~onehot) | ({WIDTH{In}} & onehot);
      if (&mask_nxt)
        state <= HOLD;
      else
        state <= COLLECT;
      if (restart)
        Overrun <= 1'b0;
      else if (drop)
        Overrun <= 1'b1;
    end
  end

`ifdef DEMUX_AUTO_EN
  // Pointer advances on auto writes; a new frame restarts it at slot 0.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      ptr <= '0;
    else if (accept && AutoMode)
      ptr <= ptr_inc;
    else if (restart)
      ptr <= '0;
  end
`endif

  assign Valid = (state == HOLD);

endmodule

// File: tb/tb_demux_capture.sv
// Bench for demux_capture: frame-level model plus directed vectors.
// Works with or without DEMUX_AUTO_EN defined.
module tb_demux_capture;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [2:0] DemuxSelect = '0;
  logic       In = 1'b0;
  logic       WrEn = 1'b0;
  logic       AutoMode = 1'b0;
  logic       Ack = 1'b0;
  logic [6:0] Out;
  logic       Valid;
  logic       Overrun;

  int nassert = 0;
  int nfail   = 0;

  demux_capture dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .DemuxSelect (DemuxSelect),
    .In          (In),
    .WrEn        (WrEn),
    .AutoMode    (AutoMode),
    .Ack         (Ack),
    .Out         (Out),
    .Valid       (Valid),
    .Overrun     (Overrun)
  );

  always #5 Clock = ~Clock;

  // Model: per-slot bits, set of written slots, pointer, frame state.
  bit [6:0] m_out = '0;
  bit [6:0] m_wr  = '0;
  int       m_ptr = 0;
  bit       m_hold = 1'b0;
  bit       m_ovr  = 1'b0;

  always @(posedge Clock or posedge Reset) begin : model
    bit [6:0] o;
    bit [6:0] w;
    int       p;
    int       t;
    bit       h;
    bit       v;
    if (Reset) begin
      m_out  <= '0;
      m_wr   <= '0;
      m_ptr  <= 0;
      m_hold <= 1'b0;
      m_ovr  <= 1'b0;
    end else begin
      o = m_out;
      w = m_wr;
      p = m_ptr;
      h = m_hold;
      v = m_ovr;
      if (h && Ack) begin
        h = 1'b0;
        w = '0;
        p = 0;
        v = 1'b0;
      end
      if (WrEn && h) begin
        v = 1'b1;
      end else if (WrEn) begin
        t = int'(DemuxSelect);
`ifdef DEMUX_AUTO_EN
        if (AutoMode) begin
          t = p;
          p = (p + 1) % 7;
        end
`endif
        if (t < 7) begin
          o[t] = In;
          w[t] = 1'b1;
        end
        h = (w == 7'h7f);
      end
      m_out  <= o;
      m_wr   <= w;
      m_ptr  <= p;
      m_hold <= h;
      m_ovr  <= v;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every cycle outside reset, DUT outputs must equal the model.
  always @(negedge Clock) begin
    if (!Reset) begin
      check("model_out", 32'(Out), 32'(m_out));
      check("model_valid", 32'(Valid), 32'(m_hold));
      check("model_overrun", 32'(Overrun), 32'(m_ovr));
    end
  end

  // One clock with the given inputs; returns just after the falling edge.
  task automatic tick(input logic wr, input logic din, input logic [2:0] sel,
                      input logic au, input logic ak);
    WrEn = wr;
    In = din;
    DemuxSelect = sel;
    AutoMode = au;
    Ack = ak;
    @(posedge Clock);
    @(negedge Clock);
    #1;
    WrEn = 1'b0;
    Ack = 1'b0;
  endtask

  task automatic async_reset();
    Reset = 1'b1;
    #1;
    check("rst_out", 32'(Out), 32'h0);
    check("rst_valid", 32'(Valid), 32'h0);
    check("rst_overrun", 32'(Overrun), 32'h0);
    #1;
    Reset = 1'b0;
  endtask

  initial begin : stim
    logic [6:0] bits;
    #2;
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    #1;
    Reset = 1'b0;
    check("init_out", 32'(Out), 32'h0);
    check("init_valid", 32'(Valid), 32'h0);
    check("init_overrun", 32'(Overrun), 32'h0);

    // Auto fill 1,0,1,1,0,0,1 (select mirrors the pointer for both builds)
    bits = 7'b1001101;
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, bits[i], 3'(i), 1'b1, 1'b0);
      if (i == 5) check("auto_valid_early", 32'(Valid), 32'h0);
    end
    check("auto_out", 32'(Out), 32'h4d);
    check("auto_valid", 32'(Valid), 32'h1);
    tick(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    check("auto_ack_valid", 32'(Valid), 32'h0);
    check("auto_ack_out", 32'(Out), 32'h4d);

    // Manual fill 6..0 with an invalid select inserted
    for (int s = 6; s >= 4; s--) tick(1'b1, 1'b1, 3'(s), 1'b0, 1'b0);
    tick(1'b1, 1'b0, 3'd7, 1'b0, 1'b0);
    check("inv_sel_out", 32'(Out), 32'h7d);
    for (int s = 3; s >= 1; s--) tick(1'b1, 1'b1, 3'(s), 1'b0, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    check("ack_collect_valid", 32'(Valid), 32'h0);
    tick(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    check("man_out", 32'(Out), 32'h7f);
    check("man_valid", 32'(Valid), 32'h1);
    tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // Rewrite slot 2 before completion
    tick(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 3'd2, 1'b0, 1'b0);
    for (int s = 3; s <= 5; s++) tick(1'b1, 1'b1, 3'(s), 1'b0, 1'b0);
    check("rew_valid_early", 32'(Valid), 32'h0);
    tick(1'b1, 1'b1, 3'd6, 1'b0, 1'b0);
    check("rew_out", 32'(Out), 32'h7b);
    check("rew_valid", 32'(Valid), 32'h1);
    tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);

    // Overrun in HOLD with 1010101
    bits = 7'b1010101;
    for (int i = 0; i < 7; i++) tick(1'b1, bits[i], 3'(i), 1'b1, 1'b0);
    tick(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
    check("ovr_out", 32'(Out), 32'h55);
    check("ovr_flag", 32'(Overrun), 32'h1);
    check("ovr_valid", 32'(Valid), 32'h1);
    tick(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);
    check("ovr_ack_flag", 32'(Overrun), 32'h0);
    check("ovr_ack_valid", 32'(Valid), 32'h0);

    // Simultaneous Ack + WrEn
    for (int i = 0; i < 7; i++) tick(1'b1, 1'b1, 3'(i), 1'b1, 1'b0);
    tick(1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    check("sim_pre_ovr", 32'(Overrun), 32'h1);
    tick(1'b1, 1'b0, 3'd0, 1'b1, 1'b1);
    check("sim_out", 32'(Out), 32'h7e);
    check("sim_valid", 32'(Valid), 32'h0);
    check("sim_ovr", 32'(Overrun), 32'h0);
    for (int i = 1; i < 7; i++) tick(1'b1, 1'b1, 3'(i), 1'b1, 1'b0);
    check("sim_refill_valid", 32'(Valid), 32'h1);
    check("sim_refill_out", 32'(Out), 32'h7e);
    tick(1'b0, 1'b0, 3'd0, 1'b1, 1'b1);

    // Reset mid-frame clears everything at once
    tick(1'b1, 1'b0, 3'd5, 1'b0, 1'b0);
    async_reset();

    // Auto mode with a conflicting select: build-dependent target
    tick(1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
`ifdef DEMUX_AUTO_EN
    check("mode_out", 32'(Out), 32'h01);
`else
    check("mode_out", 32'(Out), 32'h10);
`endif
    // Mixed-mode continuation, checked by the model
    tick(1'b1, 1'b1, 3'd3, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 3'd6, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule

// File: doc/demux_capture.md
# demux_capture

Serial-to-parallel counterpart of the 7:1 bit-select mux: routes a single input bit into one of seven storage slots, chosen either by an explicit 3-bit select or by an internal auto-increment pointer. When all seven slots have been written, it presents the 7-bit word with a `Valid`/`Ack` handshake. It sits on the receive side of lab datapaths, where single bits arrive on switches or a serial line and a parallel word is consumed downstream.

## Interface
- `WIDTH`, 7: number of slots, which is also the width of `Out`.
- `SELW`, 3: select width; select codes `>= WIDTH` are invalid.
- `Clock` in 1: rising-edge clock.
- `Reset` in 1: asynchronous, active-high reset.
- `DemuxSelect` in SELW: target slot in manual mode.
- `In` in 1: data bit to store.
- `WrEn` in 1: write strobe; one bit is written per cycle when high.
- `AutoMode` in 1: 1 selects the internal pointer, 0 selects `DemuxSelect`.
- `Ack` in 1: consumer accepts `Out` and starts a new frame.
- `Out` out WIDTH: stored word; `Out[k]` is slot k.
- `Valid` out 1: all slots have been written since the last `Ack` or reset.
- `Overrun` out 1: sticky flag; a write was dropped while `Valid` was high.

## Operation
- **Internal state:**
  - data register `Out`
  - write mask `WrMask[WIDTH-1:0]`
  - pointer `Ptr[SELW-1:0]`
  - state `COLLECT` / `HOLD`, with `Valid` = (state == `HOLD`)
- **Reset:** `Out`=0, `WrMask`=0, `Ptr`=0, state `COLLECT`, `Valid`=0, `Overrun`=0.
- **COLLECT, `WrEn`=1:**
  - Target slot is `Ptr` if `AutoMode`=1, otherwise `DemuxSelect`.
  - For a valid target t: `Out[t]`<=`In` and `WrMask[t]`<=1.
  - In auto mode, `Ptr` increments, wrapping from 6 to 0.
  - Manual writes do not move `Ptr`.
- **Invalid manual select** (3'b111): the write is ignored. No change to `Out`, `WrMask` or `Overrun`.
- **Rewriting a slot:** the new value overwrites the old one; `WrMask` is unchanged.
- **COLLECT -> HOLD:** taken on the clock edge where the updated `WrMask` becomes all ones.
- **HOLD:**
  - `Out` is frozen.
  - `WrEn` without `Ack` drops the write and sets `Overrun`=1.
- **HOLD -> COLLECT on `Ack`=1:**
  - `WrMask`=0, `Ptr`=0, `Overrun`=0.
  - `Out` keeps its old bits until they are overwritten.
- **`Ack` and `WrEn` in the same HOLD cycle:**
  - The write is accepted into the new frame. Auto mode writes slot 0 and sets `Ptr`=1; manual mode writes `DemuxSelect`.
  - The mask then holds only that bit, and `Overrun` is not set.
- **`Ack` in COLLECT:** ignored.
- **Mode changes:** switching `AutoMode` mid-frame is legal. The mask keeps accumulating, and `Ptr` resumes from its held value.

## Timing
- Write latency: `Out[t]` shows the new bit in the cycle after the `WrEn` edge.
- `Valid` rises in the cycle after the completing write, which is the earliest possible; for example, 7 consecutive auto writes give `Valid` one cycle after the 7th.
- `Valid` falls in the cycle after the `Ack` edge.
- `Overrun` sets in the cycle after the dropped-write edge.
- Reset asserted mid-frame or during `HOLD` clears all state immediately, without waiting for a clock edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `DEMUX_AUTO_EN` defined:
  - The pointer logic is built.
  - `AutoMode`=1 uses `Ptr` as described above.
- `DEMUX_AUTO_EN` undefined:
  - `Ptr` is not built.
  - `AutoMode` is ignored, and every write targets `DemuxSelect`.
  - The port list is identical in both builds.

## Test plan
- **Reset:** assert `Reset` with no clock edges -> `Out`=7'b0000000, `Valid`=0, `Overrun`=0 immediately.
- **Auto fill:** `AutoMode`=1, `In` sequence 1,0,1,1,0,0,1 on 7 consecutive `WrEn` cycles -> `Out`=7'b1001101, `Valid`=1 in the cycle after the 7th write; `Ack` -> `Valid`=0 next cycle.
- **Manual fill with edge cases:**
  - `AutoMode`=0; write slots 6,5,...,0 with `In`=1, and insert `DemuxSelect`=3'b111 with `In`=0 -> invalid write ignored, `Out`=7'b1111111, `Valid`=1.
  - Rewrite slot 2 with 0 before completion -> `Out[2]`=0 and `Valid` timing unchanged.
- **Overrun:** in `HOLD` with `Out`=7'b1010101, `WrEn`=1, `In`=0, `AutoMode`=1 -> `Out` unchanged, `Overrun`=1; then `Ack` -> `Overrun`=0, `Valid`=0.
- **Simultaneous `Ack`+`WrEn`:** in `HOLD`, auto mode, `In`=0 with the old `Out[0]`=1 -> next cycle `Out[0]`=0, `Valid`=0, `Overrun`=0; 6 more writes -> `Valid`=1.
- **Macro off:** build without `DEMUX_AUTO_EN`; `AutoMode`=1, `DemuxSelect`=3'd4, `In`=1 -> only `Out[4]` becomes 1.
